serie_paralelo_rx: RTL and testbench

SERIE_PARALELO_RX -- requirements
Module: serie_paralelo_rx

---
 rtl/serie_paralelo_rx_pkg.sv | 17 +
 rtl/serie_paralelo_rx_comma_detect.sv | 21 ++
 rtl/serie_paralelo_rx.sv | 106 ++++++++++
 tb/tb_serie_paralelo_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serie_paralelo_rx_pkg.sv
// Shared PHY definitions for the serial link: idle/alignment byte, lock depth
// and the receiver FSM encoding, used by both the transmitter and the receiver.
package serie_paralelo_rx_pkg;

    localparam logic [7:0] COMMA_DEFAULT    = 8'hBC;
    localparam int         BC_COUNT_DEFAULT = 4;

    // Receiver alignment FSM, 2-bit encoding kept stable for the legacy link.
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_LOCKING = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;

    function automatic logic is_byte_boundary(input logic [2:0] bit_cnt);
        return bit_cnt == 3'd7;
    endfunction

endpackage

// File: rtl/serie_paralelo_rx_comma_detect.sv
// Candidate-byte former and comma comparator: the byte that the shift register
// will hold after this edge, and whether it equals the idle/alignment byte.
module comma_detect
    import serie_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
    input  logic [7:0] shift,
    input  logic       data_in,
    output logic [7:0] next_byte,
    output logic       is_comma
);

    // The oldest bit falls off the window; it is intentionally not inspected.
    logic unused_shift_msb;
    assign unused_shift_msb = shift[7];

    assign next_byte = {shift[6:0], data_in};
    assign is_comma  = (next_byte == COMMA);

endmodule

// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: hunts for the comma byte at any bit offset, locks
// after BC_COUNT aligned commas, then strobes out every non-comma byte.
module serie_paralelo_rx
    import serie_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COMMA    = COMMA_DEFAULT,
    parameter int         BC_COUNT = BC_COUNT_DEFAULT
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int              BC_W   = $clog2(BC_COUNT + 1);
    localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BC_COUNT);

    logic [1:0]      state, state_nxt;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [BC_W-1:0] bc_cnt, bc_cnt_nxt, bc_inc;
    logic [7:0]      shift, next_byte;
    logic            is_comma;
    logic            at_boundary;
    logic            load_byte;

    comma_detect #(
        .COMMA (COMMA)
    ) u_comma_detect (
        .shift     (shift),
        .data_in   (data_in),
        .next_byte (next_byte),
        .is_comma  (is_comma)
    );

    always_comb begin
        // NOTE: every output of this block gets a default up front, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt + 3'd1;
        bc_cnt_nxt  = bc_cnt;
        load_byte   = 1'b0;
        at_boundary = is_byte_boundary(bit_cnt);
        bc_inc      = (bc_cnt == BC_MAX) ? BC_MAX : bc_cnt + BC_ONE;

        case (state)
            ST_SEARCH: begin
                bit_cnt_nxt = 3'd0;
                if (is_comma) begin
                    bc_cnt_nxt = BC_ONE;
                    state_nxt  = (BC_ONE == BC_MAX) ? ST_ACTIVE : ST_LOCKING;
                end
            end
            ST_LOCKING: begin
                if (at_boundary) begin
                    if (is_comma) begin
                        bc_cnt_nxt = bc_inc;
                        if (bc_inc == BC_MAX) begin
                            state_nxt = ST_ACTIVE;
                        end
                    end else begin
                        // A broken comma run means the alignment guess was wrong.
                        bc_cnt_nxt = '0;
                        state_nxt  = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                load_byte = at_boundary && !is_comma;
            end
            default: begin
                bit_cnt_nxt = 3'd0;
                bc_cnt_nxt  = '0;
                state_nxt   = ST_SEARCH;
            end
        endcase
    end

    // Reset is sampled on the clock edge, so every output changes only on clk_8f.
    always_ff @(posedge clk_8f) begin
        // NOTE: state is updated with non-blocking assignments so all registers
        // see the pre-edge values, independent of statement order.
        if (!reset) begin
            state     <= ST_SEARCH;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            bc_cnt    <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= next_byte;
            bit_cnt   <= bit_cnt_nxt;
            bc_cnt    <= bc_cnt_nxt;
            valid_out <= load_byte;
            active    <= (state_nxt == ST_ACTIVE);
            if (load_byte) begin
                data_out <= next_byte;
            end
        end
    end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Self-checking bench for serie_paralelo_rx: directed scenarios plus random
// streams, every cycle compared against a bit-counting behavioural model.
module tb_serie_paralelo_rx;

    localparam logic [7:0] COMMA    = 8'hBC;
    localparam int         BC_COUNT = 4;

    logic       clk_8f  = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    // Behavioural model: tracks the last 8 received bits as a number and how
    // many bits have passed since the comma that fixed the byte alignment.
    int m_hist;
    int m_pos;
    int m_commas;
    bit m_aligned;
    bit m_active;
    bit exp_valid;
    int exp_data;

    int         strobe_times[$];
    logic [7:0] strobe_bytes[$];
    logic [7:0] exp_bytes[$];

    serie_paralelo_rx #(
        .COMMA    (COMMA),
        .BC_COUNT (BC_COUNT)
    ) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_8f = ~clk_8f;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
        end
    endtask

    task automatic model_step(input bit rst_low, input bit b);
        exp_valid = 1'b0;
        if (rst_low) begin
            m_hist    = 0;
            m_pos     = 0;
            m_commas  = 0;
            m_aligned = 1'b0;
            m_active  = 1'b0;
            exp_data  = 0;
            return;
        end
        m_hist = (m_hist * 2 + int'(b)) % 256;
        if (!m_aligned) begin
            if (m_hist == int'(COMMA)) begin
                m_aligned = 1'b1;
                m_pos     = 0;
                m_commas  = 1;
                if (m_commas == BC_COUNT) m_active = 1'b1;
            end
        end else begin
            m_pos++;
            if (m_pos % 8 == 0) begin
                if (m_active) begin
                    if (m_hist != int'(COMMA)) begin
                        exp_data  = m_hist;
                        exp_valid = 1'b1;
                    end
                end else if (m_hist == int'(COMMA)) begin
                    m_commas++;
                    if (m_commas == BC_COUNT) m_active = 1'b1;
                end else begin
                    m_aligned = 1'b0;
                    m_commas  = 0;
                end
            end
        end
    endtask

    // One clk_8f cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic clock_in(input bit rst_low, input bit b);
        @(negedge clk_8f);
        reset   = !rst_low;
        data_in = b;
        @(posedge clk_8f);
        model_step(rst_low, b);
        #1;
        cycle++;
        check("active", {31'b0, active}, {31'b0, m_active});
        check("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
        check("data_out", {24'b0, data_out}, exp_data);
        if (valid_out === 1'b1) begin
            strobe_times.push_back(cycle);
            strobe_bytes.push_back(data_out);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) clock_in(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) clock_in(1'b0, b[i]);
    endtask

    task automatic clear_log();
        strobe_times.delete();
        strobe_bytes.delete();
    endtask

    initial begin
        logic [7:0] t2_bytes [4];
        logic [7:0] d;
        t2_bytes = '{8'hA5, 8'h3C, 8'hBC, 8'hFF};

        // Test 1: reset, then six commas; lock after the fourth.
        do_reset(2);
        check("rst_data_out", {24'b0, data_out}, 32'h0);
        check("rst_valid_out", {31'b0, valid_out}, 32'h0);
        check("rst_active", {31'b0, active}, 32'h0);
        clear_log();
        for (int k = 0; k < 6; k++) begin
            send_byte(COMMA);
            if (k == 2) check("t1_active_after_3bc", {31'b0, active}, 32'h0);
            if (k == 3) check("t1_active_after_4bc", {31'b0, active}, 32'h1);
        end
        check("t1_no_strobes", strobe_bytes.size(), 32'd0);

        // Test 2: data, data, idle, data.
        clear_log();
        for (int k = 0; k < 4; k++) send_byte(t2_bytes[k]);
        check("t2_strobe_count", strobe_bytes.size(), 32'd3);
        if (strobe_bytes.size() == 3) begin
            check("t2_byte0", {24'b0, strobe_bytes[0]}, 32'hA5);
            check("t2_byte1", {24'b0, strobe_bytes[1]}, 32'h3C);
            check("t2_byte2", {24'b0, strobe_bytes[2]}, 32'hFF);
            check("t2_gap0", strobe_times[1] - strobe_times[0], 32'd8);
            check("t2_gap1", strobe_times[2] - strobe_times[1], 32'd16);
        end

        // Test 3: misaligned start.
        do_reset(2);
        for (int i = 0; i < 3; i++) clock_in(1'b0, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 4; k++) send_byte(COMMA);
        check("t3_locked", {31'b0, active}, 32'h1);
        clear_log();
        send_byte(8'h5A);
        check("t3_data_out", {24'b0, data_out}, 32'h5A);
        check("t3_strobe_count", strobe_bytes.size(), 32'd1);

        // Test 4: interrupted comma run returns to search.
        do_reset(2);
        send_byte(COMMA);
        send_byte(COMMA);
        send_byte(8'h12);
        check("t4_not_active_after_12", {31'b0, active}, 32'h0);
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        check("t4_not_active_3bc", {31'b0, active}, 32'h0);
        send_byte(COMMA);
        check("t4_active_4bc", {31'b0, active}, 32'h1);

        // Test 5: reset in the middle of a data byte while locked.
        send_byte(8'h77);
        check("t5_data_before", {24'b0, data_out}, 32'h77);
        d = 8'hC3;
        for (int i = 7; i >= 5; i--) clock_in(1'b0, d[i]);
        clock_in(1'b1, d[4]);
        check("t5_rst_active", {31'b0, active}, 32'h0);
        check("t5_rst_data", {24'b0, data_out}, 32'h0);
        check("t5_rst_valid", {31'b0, valid_out}, 32'h0);
        for (int i = 3; i >= 0; i--) clock_in(1'b0, d[i]);
        for (int k = 0; k < 3; k++) send_byte(COMMA);
        check("t5_relock_3bc", {31'b0, active}, 32'h0);
        send_byte(COMMA);
        check("t5_relock_4bc", {31'b0, active}, 32'h1);

        // Test 6: loopback of every byte value with random idle gaps.
        do_reset(2);
        for (int k = 0; k < BC_COUNT; k++) send_byte(COMMA);
        clear_log();
        exp_bytes.delete();
        for (int v = 0; v < 256; v++) begin
            send_byte(8'(v));
            if (8'(v) != COMMA) exp_bytes.push_back(8'(v));
            for (int g = 0; g < int'($urandom_range(1, 2)); g++) send_byte(COMMA);
        end
        check("t6_strobe_count", strobe_bytes.size(), exp_bytes.size());
        if (strobe_bytes.size() == exp_bytes.size()) begin
            for (int i = 0; i < exp_bytes.size(); i++)
                check("t6_byte_order", {24'b0, strobe_bytes[i]}, {24'b0, exp_bytes[i]});
        end

        // Test 7: random streams with random prefixes and occasional broken comma runs.
        for (int run = 0; run < 4; run++) begin
            do_reset(1 + int'($urandom_range(0, 2)));
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) clock_in(1'b0, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 2) == 0) send_byte(COMMA);
                else send_byte(8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
